// File: rtl/alu8_arbiter.sv
// Two-requester round-robin front end for a shared combinational alu8.
// Grants one request at a time, registers operands, and returns the checked result.
module alu8_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_op0,
  input  logic [3:0] req_op1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_data,
  output logic       rsp_err,
  output logic [7:0] alu_a,
  output logic [7:0] alu_b,
  output logic [3:0] alu_op,
  input  logic [7:0] alu_result,
  output logic       busy
);

  localparam int unsigned DW  = 8;
  localparam int unsigned OPW = 4;
  localparam logic [OPW-1:0] OP_DIV      = OPW'(3);
  localparam logic [OPW-1:0] OP_LAST_OK  = OPW'(10);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   ptr_q;
  logic   gnt_q;
  logic   any_c;
  logic   gnt_c;
  logic   accept_c;
  logic   rsp_done_c;
  logic   div0_c;
  logic   illegal_c;

  // Round-robin pick: pointer wins ties, otherwise whichever side is valid.
  always_comb begin
    any_c      = |req_valid;
    gnt_c      = req_valid[ptr_q] ? ptr_q : ~ptr_q;
    accept_c   = (state_q == IDLE) && any_c;
    rsp_done_c = (state_q == RESP) && rsp_ready[gnt_q];
    req_ready  = '0;
    if (accept_c) req_ready[gnt_c] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_c) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (rsp_done_c) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    div0_c    = (alu_op == OP_DIV) && (alu_b == DW'(0));
    illegal_c = (alu_op > OP_LAST_OK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Datapath and response registers; abort on reset discards any in-flight result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= 1'b0;
      gnt_q     <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_op    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      busy <= (state_d != IDLE);
      if (accept_c) begin
        gnt_q  <= gnt_c;
        ptr_q  <= ~gnt_c;
        alu_a  <= gnt_c ? req_a1  : req_a0;
        alu_b  <= gnt_c ? req_b1  : req_b0;
        alu_op <= gnt_c ? req_op1 : req_op0;
      end
      if (state_q == EXEC) begin
        rsp_valid[gnt_q] <= 1'b1;
        if (div0_c) begin
          rsp_data <= 8'hFF;
          rsp_err  <= 1'b1;
        end else if (illegal_c) begin
          rsp_data <= 8'h00;
          rsp_err  <= 1'b1;
        end else begin
          rsp_data <= alu_result;
          rsp_err  <= 1'b0;
        end
      end
      if (rsp_done_c) rsp_valid <= '0;
    end
  end

endmodule

// File: tb/tb_alu8_arbiter.sv
// Directed bench for alu8_arbiter with a behavioural alu8 stand-in on the alu_* side.
module tb_alu8_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid, req_ready, rsp_valid, rsp_ready;
  logic [3:0] req_op0, req_op1, alu_op;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [7:0] rsp_data, alu_a, alu_b, alu_result;
  logic       rsp_err, busy;

  int n_cmp = 0;
  int n_err = 0;

  alu8_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1),
    .req_a0(req_a0), .req_b0(req_b0), .req_a1(req_a1), .req_b1(req_b1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_result(alu_result), .busy(busy)
  );

  always #5 clk = ~clk;

  // alu8 stand-in; div-by-zero and unassigned opcodes return junk the DUT must ignore.
  always_comb begin
    logic [15:0] prod;
    prod = 16'(alu_a) * 16'(alu_b);
    case (alu_op)
      4'h0: alu_result = alu_a + alu_b;
      4'h1: alu_result = alu_a - alu_b;
      4'h2: alu_result = prod[7:0];
      4'h3: alu_result = (alu_b == 8'h00) ? 8'hAA : alu_a / alu_b;
      4'h4: alu_result = alu_a & alu_b;
      4'h5: alu_result = alu_a | alu_b;
      4'h6: alu_result = ~alu_a;
      4'h7: alu_result = alu_a ^ alu_b;
      4'h8: alu_result = alu_a << 1;
      4'h9: alu_result = alu_a >> 1;
      4'hA: alu_result = (alu_a == alu_b) ? 8'h01 : 8'h00;
      default: alu_result = 8'h5A;
    endcase
  end

  typedef struct {
    logic       r;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic       err;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"}, int'(req_ready), 0);
    check({tag, " rsp_valid"}, int'(rsp_valid), 0);
    check({tag, " rsp_data"},  int'(rsp_data), 0);
    check({tag, " rsp_err"},   int'(rsp_err), 0);
    check({tag, " alu_a"},     int'(alu_a), 0);
    check({tag, " alu_b"},     int'(alu_b), 0);
    check({tag, " alu_op"},    int'(alu_op), 0);
    check({tag, " busy"},      int'(busy), 0);
  endtask

  task automatic drive_req(input logic r, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    if (r) begin req_op1 = op; req_a1 = a; req_b1 = b; end
    else   begin req_op0 = op; req_a0 = a; req_b0 = b; end
    req_valid[r] = 1'b1;
  endtask

  // One full transaction from a single requester with rsp_ready held high.
  task automatic run_vec(input vec_t v);
    int   waited;
    logic [1:0] oh;
    oh = 2'b01 << v.r;
    @(posedge clk); #1;
    drive_req(v.r, v.op, v.a, v.b);
    waited = 0;
    @(negedge clk);
    while (req_ready == 2'b00 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check("grant wait", waited, 0);
    if (waited >= 10) begin req_valid = 2'b00; return; end
    check("req_ready onehot", int'(req_ready), int'(oh));
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("exec rsp_valid", int'(rsp_valid), 0);
    check("exec busy", int'(busy), 1);
    @(negedge clk);
    check("rsp_valid", int'(rsp_valid), int'(oh));
    check("rsp_data", int'(rsp_data), int'(v.exp));
    check("rsp_err", int'(rsp_err), int'(v.err));
    @(negedge clk);
    check("post rsp_valid", int'(rsp_valid), 0);
    check("post busy", int'(busy), 0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = '0; rsp_ready = 2'b11;
    req_op0 = '0; req_op1 = '0; req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;

    vecs[0]  = '{1'b0, 4'h0, 8'hF0, 8'h20, 8'h10, 1'b0};
    vecs[1]  = '{1'b1, 4'h3, 8'h09, 8'h00, 8'hFF, 1'b1};
    vecs[2]  = '{1'b0, 4'hC, 8'h09, 8'h02, 8'h00, 1'b1};
    vecs[3]  = '{1'b1, 4'h3, 8'h09, 8'h02, 8'h04, 1'b0};
    vecs[4]  = '{1'b0, 4'hF, 8'h12, 8'h34, 8'h00, 1'b1};
    vecs[5]  = '{1'b0, 4'h0, 8'hA5, 8'h03, 8'hA8, 1'b0};
    vecs[6]  = '{1'b1, 4'h1, 8'hA5, 8'h03, 8'hA2, 1'b0};
    vecs[7]  = '{1'b0, 4'h2, 8'hA5, 8'h03, 8'hEF, 1'b0};
    vecs[8]  = '{1'b1, 4'h3, 8'hA5, 8'h03, 8'h37, 1'b0};
    vecs[9]  = '{1'b0, 4'h4, 8'hA5, 8'h03, 8'h01, 1'b0};
    vecs[10] = '{1'b1, 4'h5, 8'hA5, 8'h03, 8'hA7, 1'b0};
    vecs[11] = '{1'b0, 4'h6, 8'hA5, 8'h03, 8'h5A, 1'b0};
    vecs[12] = '{1'b1, 4'h7, 8'hA5, 8'h03, 8'hA6, 1'b0};
    vecs[13] = '{1'b0, 4'h8, 8'hA5, 8'h03, 8'h4A, 1'b0};
    vecs[14] = '{1'b1, 4'h9, 8'hA5, 8'h03, 8'h52, 1'b0};
    vecs[15] = '{1'b0, 4'hA, 8'hA5, 8'h03, 8'h00, 1'b0};
    vecs[16] = '{1'b1, 4'h1, 8'h03, 8'h05, 8'hFE, 1'b0};

    do_reset();
    for (int i = 0; i < 17; i++) run_vec(vecs[i]);

    // Tie from reset: grants alternate 0,1,0,1 every 3 cycles.
    do_reset();
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 8'h01, 8'h02);
    drive_req(1'b1, 4'h7, 8'h0F, 8'hF0);
    for (int k = 0; k < 4; k++) begin
      logic [1:0] oh;
      oh = (k % 2 == 0) ? 2'b01 : 2'b10;
      @(negedge clk);
      check("tie grant", int'(req_ready), int'(oh));
      @(negedge clk);
      check("tie exec", int'(rsp_valid), 0);
      @(negedge clk);
      check("tie rsp_valid", int'(rsp_valid), int'(oh));
      check("tie rsp_data", int'(rsp_data), (k % 2 == 0) ? 8'h03 : 8'hFF);
    end
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    check("tie idle busy", int'(busy), 0);

    // Backpressure on requester 1 while requester 0 waits.
    rsp_ready = 2'b01;
    @(posedge clk); #1;
    drive_req(1'b1, 4'h2, 8'h10, 8'h11);
    @(negedge clk);
    check("bp grant1", int'(req_ready), 2);
    @(posedge clk); #1;
    req_valid = 2'b00;
    drive_req(1'b0, 4'h0, 8'h03, 8'h04);
    @(negedge clk);
    check("bp exec ready", int'(req_ready), 0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp rsp_valid", int'(rsp_valid), 2);
      check("bp rsp_data", int'(rsp_data), 8'h10);
      check("bp rsp_err", int'(rsp_err), 0);
      check("bp req_ready", int'(req_ready), 0);
    end
    @(posedge clk); #1;
    rsp_ready = 2'b11;
    @(negedge clk);
    check("bp hs rsp_valid", int'(rsp_valid), 2);
    check("bp hs req_ready", int'(req_ready), 0);
    @(negedge clk);
    check("bp next grant0", int'(req_ready), 1);
    check("bp released", int'(rsp_valid), 0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("bp rsp0 valid", int'(rsp_valid), 1);
    check("bp rsp0 data", int'(rsp_data), 8'h07);
    @(negedge clk);

    // Reset while a response is pending: it must vanish.
    @(posedge clk); #1;
    drive_req(1'b0, 4'h0, 8'h01, 8'h01);
    @(negedge clk);
    check("rst grant", int'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst pre rsp_valid", int'(rsp_valid), 1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst no rsp", int'(rsp_valid), 0);
      check("rst no busy", int'(busy), 0);
    end
    run_vec('{1'b1, 4'hA, 8'h55, 8'h55, 8'h01, 1'b0});

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu8_arbiter.md
# alu8_arbiter

Two-requester round-robin arbiter and sequencer for the shared combinational `alu8` datapath. It accepts operation requests over valid/ready handshakes and drives the registered operands and opcode into one `alu8` instance. It captures the 8-bit result, flags divide-by-zero and unassigned opcodes, and returns the response to the granted requester with backpressure. It sits between the two datapath clients and the single `alu8` instance.

## Interface
- No parameters; requester count (2) and data width (8) are fixed.
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid[1:0]`  in  2  request valid, one bit per requester.
- `req_ready[1:0]`  out  2  request accepted this cycle (one-hot or zero).
- `req_op0`, `req_op1`  in  4 each  opcode from requester 0/1.
- `req_a0`, `req_b0`, `req_a1`, `req_b1`  in  8 each  operands.
- `rsp_valid[1:0]`  out  2  response valid for requester 0/1 (one-hot or zero).
- `rsp_ready[1:0]`  in  2  requester accepts response.
- `rsp_data`  out  8  result, shared by both requesters; qualified by `rsp_valid`.
- `rsp_err`  out  1  error flag, qualified by `rsp_valid`.
- `alu_a`, `alu_b`  out  8 each  registered operands to `alu8`.
- `alu_op`  out  4  registered opcode to `alu8`.
- `alu_result`  in  8  combinational result from `alu8`.
- `busy`  out  1  high in EXEC or RESP.

## Operation
- **Opcodes:**
  - 0000 add, 0001 sub, 0010 mul, 0011 div, 0100 and, 0101 or, 0110 not a, 0111 xor, 1000 shl a, 1001 shr a, 1010 eq.
  - All results are truncated to 8 bits; sub wraps modulo 256.
- **States:** IDLE, EXEC, RESP.
  - IDLE: arbitration is open. If any `req_valid` is high, grant exactly one requester and move to EXEC.
  - EXEC: the ALU output is settling. Capture into the response registers and move to RESP unconditionally.
  - RESP: hold `rsp_valid[g]` until `rsp_ready[g]`, then return to IDLE.
- **Arbitration:**
  - A single priority pointer `ptr` selects the requester that wins ties.
  - Grant `g` = `ptr` if `req_valid[ptr]`, else the other requester if it is valid.
  - `req_ready[g]` = 1 only in IDLE and only for the granted requester.
  - After each acceptance, `ptr` = ~`g`. A continuously requesting client therefore waits at most one transaction.
- **On acceptance:** latch `alu_a`/`alu_b`/`alu_op` from the granted port and latch the requester id `g`.
- **Error handling at EXEC capture:**
  - op 0011 with b == 0: `rsp_err`=1, `rsp_data`=8'hFF. `alu_result` is ignored.
  - op 1011–1111: `rsp_err`=1, `rsp_data`=8'h00.
  - Otherwise: `rsp_err`=0, `rsp_data`=`alu_result`. Eq returns 8'h01 or 8'h00.
- **Request stability:** `req_valid` may drop before grant without effect. Operands are sampled only on the accept edge.
- **Unused response port:** `rsp_ready` on the non-granted port is ignored.
- **Reset:** `rst_n` low at any time, including during EXEC or RESP, aborts the transaction. The in-flight response is discarded and never presented.

## Timing
- **Reset values:** state=IDLE, `ptr`=0, `req_ready`=0, `rsp_valid`=0, `rsp_data`=0, `rsp_err`=0, `alu_a`=`alu_b`=0, `alu_op`=0, `busy`=0.
- **Accept and response latency:**
  - Cycle 0: accept edge (`req_valid[g]` & `req_ready[g]`).
  - Cycle 1: EXEC.
  - Cycle 2: `rsp_valid[g]` rises; accept-to-response latency is 2 clocks.
- **Response hold:** `rsp_valid`/`rsp_data`/`rsp_err` are registered and remain stable until the handshake.
- **Back-to-back throughput:**
  - With `rsp_ready` held high, one operation completes every 3 cycles.
  - The next `req_ready` asserts in the cycle after the response handshake.
- **Outputs in IDLE:** `req_ready` is combinational from state, `ptr` and `req_valid`. No other output is combinational.

## Test plan
- **Reset and single add:** reset, then requester 0 sends op 0000, a=8'hF0, b=8'h20 → `req_ready[0]` in the same cycle; `rsp_valid[0]` 2 cycles later with `rsp_data`=8'h10, `rsp_err`=0.
- **Tie and rotation:** both requesters valid from reset, `rsp_ready`=2'b11 → grants go 0,1,0,1. Each response is routed to the matching `rsp_valid` bit, with 3-cycle spacing.
- **Divide by zero and illegal opcode:**
  - op 0011, a=8'h09, b=0 → `rsp_data`=8'hFF, `rsp_err`=1.
  - op 1100 → `rsp_data`=8'h00, `rsp_err`=1.
  - op 0011, a=9, b=2 → 8'h04, `rsp_err`=0.
- **Backpressure:** hold `rsp_ready[1]`=0 for 5 cycles after the response from requester 1 (op 0010, a=8'h10, b=8'h11 → 8'h10) →
  - `rsp_valid[1]`, data and err stay stable;
  - `req_ready`=0 throughout, even with requester 0 valid;
  - requester 0 is granted the cycle after the handshake.
- **Reset mid-operation:** assert `rst_n` low during RESP → all outputs return to their reset values and no response is produced. The next request (op 1010, a=b=8'h55) returns 8'h01.
- **Opcode sweep:** sweep ops 0000–1010 with a=8'hA5, b=8'h03 → results match the opcode table, including mul truncation 8'hEF, shl 8'h4A and shr 8'h52.
